ppi_xfer_sequencer: RTL
=======================

// Module: ppi_xfer_sequencer
// PURPOSE
//  Host-side ISA I/O cycle sequencer for the 8255A-style port block (mode-1 A in, B out).
//  After START it writes the control word to BASE+3, then services A-read and B-write on INTR_A / INTR_B.
//  Transfers are interrupt-driven, and a round-robin arbiter picks between A and B when both are pending.
//  Sits between a byte-stream client (RX/TX valid-ready) and the SA/SD/IOR/IOW/AEN bus pins.
// PARAMETERS
//  BASE        10'h2B0  port base address (A=+0, B=+1, control=+3)
//  SETUP_CYC   2        CLK cycles SA/SD stable before strobe, >=1
//  STROBE_CYC  4        CLK cycles IOR/IOW held low, >=1
//  HOLD_CYC    1        CLK cycles SA/SD held after strobe, >=1
// PORTS
//  CLK       in   1   single clock
//  RST       in   1   asynchronous, active-high reset
//  START     in   1   pulse: latch CFG_WORD, run config write
//  CFG_WORD  in   8   control word (mode 1, A in, B out)
//  SA        out  10  I/O address
//  SD_O      out  8   write data to bus
//  SD_I      in   8   read data from bus
//  SD_OE     out  1   1 = drive SD (write cycles only)
//  IOR       out  1   active-low read strobe
//  IOW       out  1   active-low write strobe
//  AEN       out  1   held 0 (CPU cycle)
//  INTR_A    in   1   port A byte ready (async, 2-flop sync)
//  INTR_B    in   1   port B buffer free (async, 2-flop sync)
//  RX_DATA   out  8   byte read from port A
//  RX_VALID  out  1   RX_DATA valid
//  RX_READY  in   1   client accepts RX byte
//  TX_DATA   in   8   byte for port B
//  TX_VALID  in   1   TX_DATA valid
//  TX_READY  out  1   1 = TX holding register empty
//  CFG_DONE  out  1   control word written
//  BUSY      out  1   bus cycle in progress
// BEHAVIOUR
//  Reset values:
//   - IOR=1, IOW=1, SD_OE=0, SA=0, SD_O=0, AEN=0
//   - RX_VALID=0, TX_READY=1, CFG_DONE=0, BUSY=0, rr pointer=A
//  FSM: WAIT_CFG -> ARB -> SETUP -> STROBE -> HOLD -> ARB
//   - WAIT_CFG: START latches CFG_WORD; issues write to BASE+3. On HOLD exit: CFG_DONE=1, go to ARB.
//   - ARB: picks one request per cycle; stays in ARB if none.
//      reqA = INTR_A_sync & armA & ~RX_VALID
//      reqB = INTR_B_sync & armB & tx_full
//   - Both requests: grant the side the rr pointer names; pointer then moves to the other side.
//   - SETUP: SA=target; SD_OE=1 and SD_O=data on writes; strobes high; SETUP_CYC cycles.
//   - STROBE: IOR or IOW = 0 for STROBE_CYC cycles.
//      Read: SD_I captured on the last STROBE cycle.
//   - HOLD: strobes high; SA/SD kept for HOLD_CYC cycles; then SD_OE=0.
//  Cycle length = SETUP+STROBE+HOLD clocks, plus 1 ARB cycle.
//  A read completion: RX_DATA=captured byte, RX_VALID=1; armA=0.
//   - RX_VALID clears on RX_VALID&RX_READY.
//   - armA=1 again once INTR_A_sync is seen low.
//  B write:
//   - TX_VALID&TX_READY loads tx_hold and sets tx_full; TX_READY = ~tx_full.
//   - On HOLD exit: tx_full=0, armB=0. armB=1 again once INTR_B_sync is seen low.
//  Re-arm prevents a second service on a stale, not-yet-dropped INTR.
//  Before CFG_DONE, INTR_A/B are ignored.
//  START while CFG_DONE=1 (checked in ARB): rewrites the control word. Config takes priority over A/B.
//  RX full: A is deferred and no read is issued; B continues.
//  RST mid-cycle: strobes deassert and SD_OE drops immediately (async).
//   - Any partial byte is discarded; CFG_DONE=0.
//  Counters: width clog2(max param)+1; reload on every state entry; no wrap.
// STRUCTURE
//  Package ppi_pkg:
//   - state enum, port offsets (OFS_A=0, OFS_B=1, OFS_CTL=3)
//   - default mode-1 control word 8'hB4
//  Sub-module isa_io_cycle holds the SETUP/STROBE/HOLD counters and bus pins.
//   - Inputs: go, rd_wr, addr, wdata. Outputs: done, rdata.
//  Top level holds the arbiter, sync flops, and RX/TX registers.
// TESTING
//  1. START, CFG_WORD=8'hB4 -> one IOW cycle at SA=0x2B3, SD_O=B4. Strobe low exactly 4 clk; CFG_DONE=1 after HOLD.
//  2. INTR_A=1, bus model returns 8'h5A -> IOR cycle at 0x2B0, RX_DATA=5A, RX_VALID=1.
//     INTR_A held high -> no second read until INTR_A drops.
//  3. TX byte 8'hC3, INTR_B=1 -> IOW at 0x2B1 with SD_O=C3, TX_READY returns 1 after HOLD.
//  4. INTR_A, INTR_B, tx_full all set together -> grants alternate A,B,A,B over 4 re-armed rounds.
//  5. RX_VALID=1 with RX_READY=0 and INTR_A re-armed -> no IOR issued; B writes still proceed.
//  6. RST asserted during STROBE -> IOR/IOW=1 and SD_OE=0 same cycle; CFG_DONE=0; INTR ignored until next START.

Source files
------------

// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255A-style port sequencer.
// Holds the sequencer/bus-phase enums, port offsets and the default mode-1 control word.
package ppi_pkg;

  typedef enum logic [1:0] {
    SQ_WAIT_CFG = 2'd0,
    SQ_ARB      = 2'd1,
    SQ_XFER     = 2'd2
  } seq_e;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    XK_CFG = 2'd0,
    XK_A   = 2'd1,
    XK_B   = 2'd2
  } xfer_e;

  localparam logic [9:0] OFS_A   = 10'd0;
  localparam logic [9:0] OFS_B   = 10'd1;
  localparam logic [9:0] OFS_CTL = 10'd3;

  localparam logic [7:0] CW_MODE1_DEFAULT = 8'hB4;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/isa_io_cycle.sv
// One ISA I/O bus cycle: SETUP, STROBE and HOLD phases with registered bus pins.
// done_o flags the last HOLD cycle so the caller can re-arbitrate on the very next clock.
module isa_io_cycle
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go_i,
  input  logic       rd_wr_i,
  input  logic [9:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] sd_in_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [9:0] sa_o,
  output logic [7:0] sd_out_o,
  output logic       sd_oe_o,
  output logic       ior_n_o,
  output logic       iow_n_o
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, rd_d;
  logic [9:0]       sa_q, sa_d;
  logic [7:0]       sd_o_q, sd_o_d;
  logic             sd_oe_q, sd_oe_d;
  logic             ior_q, ior_d;
  logic             iow_q, iow_d;
  logic [7:0]       rdata_q, rdata_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q <= PH_IDLE;
      cnt_q   <= CNT_ZERO;
      rd_q    <= 1'b0;
      sa_q    <= 10'd0;
      sd_o_q  <= 8'd0;
      sd_oe_q <= 1'b0;
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      rdata_q <= 8'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      sa_q    <= sa_d;
      sd_o_q  <= sd_o_d;
      sd_oe_q <= sd_oe_d;
      ior_q   <= ior_d;
      iow_q   <= iow_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes default high; they are driven low only for the cycles spent in STROBE.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    sa_d    = sa_q;
    sd_o_d  = sd_o_q;
    sd_oe_d = sd_oe_q;
    ior_d   = 1'b1;
    iow_d   = 1'b1;
    rdata_d = rdata_q;
    case (phase_q)
      PH_IDLE: begin
        if (go_i) begin
          phase_d = PH_SETUP;
          cnt_d   = CNT_W'(SETUP_CYC - 1);
          rd_d    = rd_wr_i;
          sa_d    = addr_i;
          if (!rd_wr_i) begin
            sd_o_d  = wdata_i;
            sd_oe_d = 1'b1;
          end else begin
            sd_oe_d = 1'b0;
          end
        end else begin
          phase_d = PH_IDLE;
        end
      end
      PH_SETUP: begin
        if (cnt_q == CNT_ZERO) begin
          phase_d = PH_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
          ior_d   = ~rd_q;
          iow_d   = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      PH_STROBE: begin
        if (cnt_q == CNT_ZERO) begin
          phase_d = PH_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          if (rd_q) begin
            rdata_d = sd_in_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          ior_d = ~rd_q;
          iow_d = rd_q;
        end
      end
      PH_HOLD: begin
        if (cnt_q == CNT_ZERO) begin
          phase_d = PH_IDLE;
          sd_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        sd_oe_d = 1'b0;
      end
    endcase
  end

  assign done_o   = (phase_q == PH_HOLD) && (cnt_q == CNT_ZERO);
  assign rdata_o  = rdata_q;
  assign sa_o     = sa_q;
  assign sd_out_o = sd_o_q;
  assign sd_oe_o  = sd_oe_q;
  assign ior_n_o  = ior_q;
  assign iow_n_o  = iow_q;

endmodule

// File: rtl/ppi_xfer_sequencer.sv
// Host-side sequencer for an 8255A-style port block in mode 1 (A in, B out).
// Writes the control word on START, then services INTR_A reads and INTR_B writes round-robin.
module ppi_xfer_sequencer
  import ppi_pkg::*;
#(
  parameter logic [9:0] BASE       = 10'h2B0,
  parameter int         SETUP_CYC  = 2,
  parameter int         STROBE_CYC = 4,
  parameter int         HOLD_CYC   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] CFG_WORD,
  output logic [9:0] SA,
  output logic [7:0] SD_O,
  input  logic [7:0] SD_I,
  output logic       SD_OE,
  output logic       IOR,
  output logic       IOW,
  output logic       AEN,
  input  logic       INTR_A,
  input  logic       INTR_B,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       CFG_DONE,
  output logic       BUSY
);

  seq_e       state_q, state_d;
  xfer_e      kind_q, kind_d;
  logic       rr_q, rr_d;
  logic [1:0] sync_a_q, sync_b_q;
  logic       arm_a_q, arm_a_d, arm_b_q, arm_b_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_empty_q, tx_empty_d;
  logic       cfg_done_q, cfg_done_d;
  logic       busy_q, busy_d;

  logic       go_s, rd_s, done_s, req_a_s, req_b_s;
  logic [9:0] addr_s;
  logic [7:0] wdata_s, rdata_s;

  assign req_a_s = sync_a_q[1] & arm_a_q & ~rx_valid_q;
  assign req_b_s = sync_b_q[1] & arm_b_q & ~tx_empty_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= SQ_WAIT_CFG;
      kind_q     <= XK_CFG;
      rr_q       <= RR_A;
      sync_a_q   <= 2'b00;
      sync_b_q   <= 2'b00;
      arm_a_q    <= 1'b0;
      arm_b_q    <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_hold_q  <= 8'd0;
      tx_empty_q <= 1'b1;
      cfg_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      rr_q       <= rr_d;
      sync_a_q   <= {sync_a_q[0], INTR_A};
      sync_b_q   <= {sync_b_q[0], INTR_B};
      arm_a_q    <= arm_a_d;
      arm_b_q    <= arm_b_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_hold_q  <= tx_hold_d;
      tx_empty_q <= tx_empty_d;
      cfg_done_q <= cfg_done_d;
      busy_q     <= busy_d;
    end
  end

  // A side is only re-armed after its INTR has been seen low, so a stale INTR cannot retrigger.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    rr_d       = rr_q;
    arm_a_d    = sync_a_q[1] ? arm_a_q : 1'b1;
    arm_b_d    = sync_b_q[1] ? arm_b_q : 1'b1;
    rx_data_d  = rx_data_q;
    rx_valid_d = (rx_valid_q && RX_READY) ? 1'b0 : rx_valid_q;
    tx_hold_d  = (TX_VALID && tx_empty_q) ? TX_DATA : tx_hold_q;
    tx_empty_d = (TX_VALID && tx_empty_q) ? 1'b0 : tx_empty_q;
    cfg_done_d = cfg_done_q;
    busy_d     = busy_q;
    go_s       = 1'b0;
    rd_s       = 1'b0;
    addr_s     = BASE + OFS_CTL;
    wdata_s    = CFG_WORD;
    case (state_q)
      SQ_WAIT_CFG: begin
        if (START) begin
          go_s    = 1'b1;
          kind_d  = XK_CFG;
          state_d = SQ_XFER;
          busy_d  = 1'b1;
        end else begin
          state_d = SQ_WAIT_CFG;
        end
      end
      SQ_ARB: begin
        if (START) begin
          go_s    = 1'b1;
          kind_d  = XK_CFG;
          state_d = SQ_XFER;
          busy_d  = 1'b1;
        end else if (req_a_s && (!req_b_s || rr_q == RR_A)) begin
          go_s    = 1'b1;
          rd_s    = 1'b1;
          addr_s  = BASE + OFS_A;
          kind_d  = XK_A;
          state_d = SQ_XFER;
          busy_d  = 1'b1;
          rr_d    = req_b_s ? RR_B : rr_q;
        end else if (req_b_s) begin
          go_s    = 1'b1;
          addr_s  = BASE + OFS_B;
          wdata_s = tx_hold_q;
          kind_d  = XK_B;
          state_d = SQ_XFER;
          busy_d  = 1'b1;
          rr_d    = req_a_s ? RR_A : rr_q;
        end else begin
          state_d = SQ_ARB;
        end
      end
      SQ_XFER: begin
        if (done_s) begin
          state_d = SQ_ARB;
          busy_d  = 1'b0;
          case (kind_q)
            XK_CFG: cfg_done_d = 1'b1;
            XK_A: begin
              rx_data_d  = rdata_s;
              rx_valid_d = 1'b1;
              arm_a_d    = 1'b0;
            end
            XK_B: begin
              tx_empty_d = 1'b1;
              arm_b_d    = 1'b0;
            end
            default: cfg_done_d = cfg_done_q;
          endcase
        end else begin
          state_d = SQ_XFER;
        end
      end
      default: begin
        state_d = SQ_WAIT_CFG;
        busy_d  = 1'b0;
      end
    endcase
  end

  isa_io_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cycle (
    .clk_i   (CLK),
    .rst_i   (RST),
    .go_i    (go_s),
    .rd_wr_i (rd_s),
    .addr_i  (addr_s),
    .wdata_i (wdata_s),
    .sd_in_i (SD_I),
    .done_o  (done_s),
    .rdata_o (rdata_s),
    .sa_o    (SA),
    .sd_out_o(SD_O),
    .sd_oe_o (SD_OE),
    .ior_n_o (IOR),
    .iow_n_o (IOW)
  );

  assign AEN      = 1'b0;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign TX_READY = tx_empty_q;
  assign CFG_DONE = cfg_done_q;
  assign BUSY     = busy_q;

endmodule
